// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline: hazard stalls, branch squash,
// HALT drain and a debug run/step/halt FSM gating global advance.
module pipeline_ctrl #(
    parameter logic [5:0] HALT_OPCODE  = 6'b111111,
    parameter int         DRAIN_CYCLES = 3,
    parameter int         CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dbg_run,
    input  logic             dbg_step,
    input  logic             dbg_halt_req,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    output logic             pipe_enable,
    output logic             pc_write,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [DW-1:0]    drain_reg, drain_next;
    logic [CNT_W-1:0] count_reg;

    logic load_use;
    logic halt_dec;

    assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                      ((idex_rt == id_rs) || (idex_rt == id_rt));
    // A load-use stall masks HALT: the instruction in ID is re-examined next cycle.
    assign halt_dec = !load_use && (id_opcode == HALT_OPCODE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            drain_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
            if (pipe_enable && (count_reg != '1))
                count_reg <= count_reg + 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        drain_next  = drain_reg;
        pipe_enable = 1'b0;
        pc_write    = 1'b0;
        ifid_stall  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (dbg_run)
                    state_next = RUN;
                else if (dbg_step)
                    state_next = STEP;
            end

            RUN, STEP: begin
                pipe_enable = 1'b1;
                ifid_stall  = 1'b0;
                if (load_use) begin
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (halt_dec) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (branch_taken) begin
                    pc_write   = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_write = 1'b1;
                end

                if (halt_dec) begin
                    state_next = DRAIN;
                    drain_next = DW'(DRAIN_CYCLES - 1);
                end else if (state_reg == STEP || dbg_halt_req) begin
                    state_next = IDLE;
                end
            end

            DRAIN: begin
                pipe_enable = 1'b1;
                ifid_stall  = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (drain_reg == '0)
                    state_next = DONE;
                else
                    drain_next = drain_reg - 1'b1;
            end

            DONE: begin
                halted = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign state       = state_reg;
    assign cycle_count = count_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs driven on the falling edge,
// combinational outputs checked 1 time unit later.
module tb_pipeline_ctrl;

    logic        clk;
    logic        reset;
    logic        dbg_run, dbg_step, dbg_halt_req;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt;
    logic        idex_mem_read;
    logic [4:0]  idex_rt;
    logic        branch_taken;
    logic        pipe_enable, pc_write, ifid_stall, ifid_flush, idex_bubble, halted;
    logic [2:0]  state;
    logic [31:0] cycle_count;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_ctrl #(
        .HALT_OPCODE (6'b111111),
        .DRAIN_CYCLES(3),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dbg_run      (dbg_run),
        .dbg_step     (dbg_step),
        .dbg_halt_req (dbg_halt_req),
        .id_opcode    (id_opcode),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .idex_mem_read(idex_mem_read),
        .idex_rt      (idex_rt),
        .branch_taken (branch_taken),
        .pipe_enable  (pipe_enable),
        .pc_write     (pc_write),
        .ifid_stall   (ifid_stall),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .halted       (halted),
        .state        (state),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Full output vector: state, pipe_enable, pc_write, stall, flush, bubble, halted.
    task automatic check_out(input string tag, input logic [2:0] st, input logic pe,
                             input logic pcw, input logic stl, input logic fl,
                             input logic bub, input logic hlt);
        check_eq({tag, ".vec"},
                 {25'd0, state, pipe_enable, pc_write, ifid_stall, ifid_flush, idex_bubble, halted},
                 {25'd0, st, pe, pcw, stl, fl, bub, hlt});
    endtask

    task automatic clear_inputs();
        dbg_run = 0; dbg_step = 0; dbg_halt_req = 0;
        id_opcode = 6'd0; id_rs = 5'd0; id_rt = 5'd0;
        idex_mem_read = 0; idex_rt = 5'd0; branch_taken = 0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();

        // Reset state
        @(negedge clk); #1;
        check_out("reset", 3'd0, 0, 0, 1, 0, 0, 0);
        check_eq("reset.count", cycle_count, 32'd0);
        reset = 1'b0;

        // Single step with a nop in ID
        next_cycle(); dbg_step = 1; #1;
        check_out("idle_step_req", 3'd0, 0, 0, 1, 0, 0, 0);
        next_cycle(); #1;
        check_out("step", 3'd2, 1, 1, 0, 0, 0, 0);
        next_cycle(); #1;
        check_out("step_back_idle", 3'd0, 0, 0, 1, 0, 0, 0);
        check_eq("step.count", cycle_count, 32'd1);

        // Enter RUN; load-use on rs
        next_cycle(); dbg_run = 1;
        next_cycle(); idex_mem_read = 1; idex_rt = 5'd5; id_rs = 5'd5; #1;
        check_out("lu_rs", 3'd1, 1, 0, 1, 0, 1, 0);
        next_cycle(); idex_rt = 5'd5; id_rs = 5'd5; #1;
        check_out("lu_resume", 3'd1, 1, 1, 0, 0, 0, 0);
        next_cycle(); idex_mem_read = 1; #1;
        check_out("lu_rt0", 3'd1, 1, 1, 0, 0, 0, 0);

        // Branch squash, then branch masked by load-use on rt
        next_cycle(); branch_taken = 1; #1;
        check_out("branch", 3'd1, 1, 1, 0, 1, 0, 0);
        next_cycle(); branch_taken = 1; idex_mem_read = 1; idex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd1; #1;
        check_out("branch_lu", 3'd1, 1, 0, 1, 0, 1, 0);

        // Halt request from RUN
        next_cycle(); dbg_halt_req = 1; #1;
        check_out("halt_req_cycle", 3'd1, 1, 1, 0, 0, 0, 0);
        next_cycle(); #1;
        check_out("paused", 3'd0, 0, 0, 1, 0, 0, 0);
        check_eq("paused.count", cycle_count, 32'd7);
        next_cycle(); #1;
        check_eq("paused.count_frozen", cycle_count, 32'd7);

        // run+step together selects RUN
        next_cycle(); dbg_run = 1; dbg_step = 1;
        next_cycle(); #1;
        check_out("run_wins", 3'd1, 1, 1, 0, 0, 0, 0);

        // HALT decoded together with halt request: DRAIN wins
        next_cycle(); id_opcode = 6'b111111; dbg_halt_req = 1; #1;
        check_out("halt_dec", 3'd1, 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); dbg_run = 1; idex_mem_read = 1; idex_rt = 5'd3; id_rs = 5'd3; #1;
            check_out($sformatf("drain%0d", i), 3'd3, 1, 0, 0, 1, 1, 0);
        end
        next_cycle(); dbg_run = 1; #1;
        check_out("done", 3'd4, 0, 0, 1, 0, 0, 1);
        check_eq("done.count", cycle_count, 32'd12);
        next_cycle(); dbg_step = 1; #1;
        check_out("done_sticky", 3'd4, 0, 0, 1, 0, 0, 1);
        check_eq("done.count_frozen", cycle_count, 32'd12);

        // Asynchronous reset in the middle of DRAIN
        reset = 1'b1;
        next_cycle(); reset = 1'b0;
        next_cycle(); dbg_run = 1;
        next_cycle(); id_opcode = 6'b111111;
        next_cycle(); #1;
        check_out("pre_async_drain", 3'd3, 1, 0, 0, 1, 1, 0);
        #2 reset = 1'b1;
        #1;
        check_out("async_reset", 3'd0, 0, 0, 1, 0, 0, 0);
        check_eq("async_reset.count", cycle_count, 32'd0);
        next_cycle(); reset = 1'b0; #1;
        check_out("after_reset", 3'd0, 0, 0, 1, 0, 0, 0);

        // Step on a HALT goes straight to DRAIN
        next_cycle(); dbg_step = 1;
        next_cycle(); id_opcode = 6'b111111; #1;
        check_out("step_halt", 3'd2, 1, 0, 0, 1, 1, 0);
        next_cycle(); #1;
        check_out("step_halt_drain", 3'd3, 1, 0, 0, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
